// File: rtl/stream_if_fifo_if.sv
// ---------------------------------------------------------------------------
// stream_if : valid/ready streaming handshake bundle.
//
// Members
//   data  [WIDTH-1:0]  payload, meaningful while valid=1
//   valid              producer has a word on data
//   ready              consumer can take a word this cycle
//
// Modports
//   src  : producer view (drives data/valid, reads ready)
//   snk  : consumer view (reads data/valid, drives ready)
// ---------------------------------------------------------------------------
interface stream_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport src (output data, output valid, input ready);
    modport snk (input data, input valid, output ready);
endinterface

// File: rtl/stream_if_fifo.sv
// ---------------------------------------------------------------------------
// stream_if_fifo : synchronous FIFO between two stream_if handshakes, with an
// occupancy output and a clearable high-water mark.
//
// Parameters
//   WIDTH      data width of both stream ports
//   DEPTH      number of storage entries (power of two, >= 2)
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset (clears pointers, counters and
//              every storage entry)
//   up         upstream stream (snk view): accepts data when up.ready=1
//   dn         downstream stream (src view): offers head entry when dn.valid=1
//   hwm_clr    synchronous clear of max_count to the next occupancy
//   count      current occupancy, 0..DEPTH
//   max_count  peak occupancy since reset or last hwm_clr
//
// Handshake outputs (up.ready, dn.valid) depend only on registered state, so
// there is no combinational path from up.valid or dn.ready through the FIFO.
// Read data comes straight from the storage array (no bypass), giving one
// cycle from push edge to visibility on dn.
// ---------------------------------------------------------------------------
module stream_if_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    stream_if.snk                        up,
    stream_if.src                        dn,
    input  logic                         hwm_clr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   max_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_max;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;

    // Status straight from the occupancy register.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Handshake qualification: a full FIFO ignores up.valid, an empty one
    // ignores dn.ready.
    assign w_push = up.valid && !w_full;
    assign w_pop  = dn.ready && !w_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage: only the write pointer slot is written. When full no write
    // happens, so the head entry can never be overwritten while it waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= up.data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Occupancy and high-water mark. The mark tracks the post-edge count so
    // that it is never behind count; hwm_clr restarts it from that value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_max   <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (hwm_clr) begin
                r_max <= w_count_nxt;
            end else if (w_count_nxt > r_max) begin
                r_max <= w_count_nxt;
            end
        end
    end

    assign up.ready  = !w_full;
    assign dn.valid  = !w_empty;
    assign dn.data   = r_mem[r_rptr];
    assign count     = r_count;
    assign max_count = r_max;

endmodule

// File: tb/tb_stream_if_fifo.sv
module tb_stream_if_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       hwm_clr;
    logic [2:0] count;
    logic [2:0] max_count;

    stream_if #(.WIDTH(WIDTH)) up_if ();
    stream_if #(.WIDTH(WIDTH)) dn_if ();

    stream_if_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up        (up_if),
        .dn        (dn_if),
        .hwm_clr   (hwm_clr),
        .count     (count),
        .max_count (max_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents in arrival order plus the peak occupancy.
    logic [7:0] mq[$];
    int         mmax;
    int         checks;
    int         errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(mq.size()));
        chk("max_count", 32'(max_count), 32'(mmax));
        chk("up_ready", 32'(up_if.ready), 32'(mq.size() != DEPTH));
        chk("dn_valid", 32'(dn_if.valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("dn_data", 32'(dn_if.data), 32'(mq[0]));
    endtask

    // One clock: predict push/pop from the model's occupancy, advance the
    // model at the edge, then compare all outputs just after the edge.
    task automatic step();
        bit         push;
        bit         pop;
        bit         clr;
        logic [7:0] pdata;
        push  = up_if.valid && (mq.size() != DEPTH);
        pop   = dn_if.ready && (mq.size() != 0);
        clr   = hwm_clr;
        pdata = up_if.data;
        @(posedge clk);
        if (rst_n) begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(pdata);
            if (clr) mmax = mq.size();
            else if (mq.size() > mmax) mmax = mq.size();
        end else begin
            mq.delete();
            mmax = 0;
        end
        #1;
        check_all();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mmax   = 0;

        // Reset held with upstream offering data.
        rst_n      = 1'b0;
        hwm_clr    = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 8'h5A;
        dn_if.ready = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dn_valid", 32'(dn_if.valid), 32'd0);
        chk("rst_up_ready", 32'(up_if.ready), 32'd1);
        chk("rst_dn_data", 32'(dn_if.data), 32'h00);
        chk("rst_max", 32'(max_count), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // First push after reset, visible one cycle later.
        up_if.data = 8'hAB;
        step();
        up_if.valid = 1'b0;
        chk("first_valid", 32'(dn_if.valid), 32'd1);
        chk("first_data", 32'(dn_if.data), 32'hAB);
        dn_if.ready = 1'b1;
        step();
        dn_if.ready = 1'b0;

        // Fill to full with the consumer stalled.
        up_if.valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            up_if.data = 8'(i * 8'h11);
            step();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(up_if.ready), 32'd0);
        up_if.data = 8'h55;
        step();
        step();
        chk("full_no_store", 32'(count), 32'd4);
        chk("full_head_stable", 32'(dn_if.data), 32'h11);
        up_if.valid = 1'b0;
        dn_if.ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 32'(dn_if.data), 32'(8'(i * 8'h11)));
            step();
        end
        chk("drain_empty", 32'(dn_if.valid), 32'd0);
        step();
        dn_if.ready = 1'b0;

        // Simultaneous push and pop at count 2.
        up_if.valid = 1'b1;
        up_if.data = 8'h61; step();
        up_if.data = 8'h62; step();
        up_if.data = 8'hCD;
        dn_if.ready = 1'b1;
        step();
        chk("pushpop_count", 32'(count), 32'd2);
        up_if.valid = 1'b0;
        chk("pushpop_head", 32'(dn_if.data), 32'h62);
        step();
        chk("pushpop_last", 32'(dn_if.data), 32'hCD);
        step();
        chk("pushpop_empty", 32'(dn_if.valid), 32'd0);

        // Back-to-back traffic through the pointer wrap.
        up_if.valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            up_if.data = 8'(i);
            step();
            chk("wrap_data", 32'(dn_if.data), 32'(i));
            chk("wrap_count_le1", 32'(count <= 3'd1), 32'd1);
        end
        up_if.valid = 1'b0;
        step();
        dn_if.ready = 1'b0;

        // High-water mark: clear, fill to 3, drain, then clear at count 1.
        hwm_clr = 1'b1; step(); hwm_clr = 1'b0;
        chk("hwm_cleared", 32'(max_count), 32'd0);
        up_if.valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_if.data = 8'(8'hA0 + i);
            step();
        end
        up_if.valid = 1'b0;
        dn_if.ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        dn_if.ready = 1'b0;
        chk("hwm_peak3", 32'(max_count), 32'd3);
        up_if.valid = 1'b1; up_if.data = 8'hB1; step(); up_if.valid = 1'b0;
        hwm_clr = 1'b1; step(); hwm_clr = 1'b0;
        chk("hwm_clr_at1", 32'(max_count), 32'd1);

        // Asynchronous reset in the middle of a cycle at count 3.
        up_if.valid = 1'b1;
        up_if.data = 8'hC2; step();
        up_if.data = 8'hC3; step();
        up_if.valid = 1'b0;
        chk("pre_reset_count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        mmax = 0;
        chk("async_count", 32'(count), 32'd0);
        chk("async_dn_valid", 32'(dn_if.valid), 32'd0);
        chk("async_max", 32'(max_count), 32'd0);
        chk("async_dn_data", 32'(dn_if.data), 32'h00);
        dn_if.ready = 1'b1;
        step();
        rst_n = 1'b1;
        dn_if.ready = 1'b0;
        step();

        // Randomized valid/ready/clear traffic against the model.
        for (int i = 0; i < 500; i++) begin
            up_if.valid = 1'($urandom_range(0, 1));
            up_if.data  = 8'($urandom);
            dn_if.ready = ($urandom_range(0, 3) != 0) ? ((i / 64) % 2 == 0) || ($urandom_range(0, 1) == 1) : 1'b0;
            hwm_clr     = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_if_fifo.md
STREAM_IF_FIFO -- requirements
Module: stream_if_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width of both interface ports.
REQ-002 SHALL have parameter DEPTH, default 4, giving the number of storage entries; a power of two, >= 2.
REQ-003 SHALL use interface stream_if #(WIDTH), members: data [WIDTH-1:0], valid, ready.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port up, stream_if interface port, WIDTH, upstream side; reads up.data and up.valid, drives up.ready.
REQ-007 SHALL have port dn, stream_if interface port, WIDTH, downstream side; drives dn.data and dn.valid, reads dn.ready.
REQ-008 SHALL have port hwm_clr, input, 1, synchronous clear of the high-water mark.
REQ-009 SHALL have port count, output, $clog2(DEPTH+1), current occupancy.
REQ-010 SHALL have port max_count, output, $clog2(DEPTH+1), peak occupancy since reset or last clear.

Function
REQ-011 SHALL define push = up.valid && up.ready and pop = dn.valid && dn.ready, both sampled at the rising clk edge.
REQ-012 SHALL drive up.ready = (count != DEPTH) combinationally from registered state, with no path from up.valid.
REQ-013 SHALL drive dn.valid = (count != 0) combinationally from registered state, with no path from dn.ready.
REQ-014 SHALL drive dn.data = storage entry at the read pointer (combinational array read).
REQ-015 SHALL on push write up.data at the write pointer and advance it modulo DEPTH.
REQ-016 SHALL on pop advance the read pointer modulo DEPTH.
REQ-017 SHALL make pushed data visible on dn one cycle after the push edge (latency 1, no bypass).
REQ-018 SHALL update count as: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
REQ-019 SHALL when not empty and not full accept a simultaneous push and pop in the same cycle, leaving count unchanged and data order preserved.
REQ-020 SHALL when full (up.ready=0) ignore up.valid; a pop that cycle drops count to DEPTH-1, and up.ready returns to 1 the next cycle.
REQ-021 SHALL when empty (dn.valid=0) ignore dn.ready; count never underflows.
REQ-022 SHALL wrap pointers from DEPTH-1 to 0 with no loss or duplication of data.
REQ-023 SHALL keep dn.data stable while dn.valid=1 and dn.ready=0 (upstream writes never overwrite the head entry).
REQ-024 SHALL each cycle load max_count with the larger of max_count and the next count value.
REQ-025 SHALL when hwm_clr=1 load max_count with the next count value, overriding REQ-024 for that cycle.
REQ-026 SHALL be a pure FIFO: data leaves in arrival order, and nothing is dropped or duplicated under any valid/ready pattern.

Reset
REQ-027 SHALL while rst_n=0, regardless of clk: clear both pointers, count=0, max_count=0, all storage entries=0, so dn.valid=0, dn.data=0 and up.ready=1.
REQ-028 SHALL on reset asserted mid-operation discard all stored entries immediately; no pop completes on that edge.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification (WIDTH=8, DEPTH=4)
REQ-030 SHALL cover reset: rst_n=0 with up.valid=1 -> count=0, dn.valid=0, up.ready=1, dn.data=8'h00; after release, push 8'hAB -> next cycle dn.valid=1, dn.data=8'hAB.
REQ-031 SHALL cover fill/full: push 8'h11, 8'h22, 8'h33, 8'h44 with dn.ready=0 -> count=4, up.ready=0; push 8'h55 offered -> not stored; drain -> 11, 22, 33, 44 in order, then dn.valid=0.
REQ-032 SHALL cover simultaneous push/pop: at count=2, push 8'hCD with pop in the same cycle -> count stays 2; output order unchanged, 8'hCD emitted last.
REQ-033 SHALL cover wrap-around: 10 back-to-back push/pop pairs of 8'h00..8'h09 with dn.ready=1 -> outputs 00..09 each exactly once, count never above 1.
REQ-034 SHALL cover the high-water mark: fill to 3, drain to 0 -> max_count=3; pulse hwm_clr at count=1 -> max_count=1 next cycle.
REQ-035 SHALL cover mid-operation reset: at count=3, assert rst_n=0 between clk edges -> count, dn.valid and max_count are 0 immediately, without waiting for a clk edge.
